// File: rtl/allocator_mac.sv
// Window allocator with a 2-stage signed multiply-accumulate.
// Sums data*weight over broadcast beats that land inside a (2h+1)^2 x D window.
module allocator_mac #(
  parameter int ACC_WIDTH = 48
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  position_x,
  input  logic [7:0]                  position_y,
  input  logic                        position_select,
  input  logic [1:0]                  filter_halfsize,
  input  logic [8:0]                  image_depth,
  input  logic [7:0]                  issue_x,
  input  logic [7:0]                  issue_y,
  input  logic signed [17:0]          issue_data,
  input  logic signed [17:0]          weight_data,
  input  logic                        issue_en,
  output logic                        issue_block,
  output logic signed [ACC_WIDTH-1:0] result_data,
  output logic                        result_valid,
  input  logic                        result_ready,
  output logic                        overrun
);

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, RESULT} state_t;

  state_t state, state_next;

  logic [7:0]  cx, cy;
  logic [1:0]  h;
  logic [14:0] target, count;

  logic        pend_full;
  logic [7:0]  pend_x, pend_y;
  logic [1:0]  pend_h;
  logic [8:0]  pend_d;

  logic        start, start_from_pend, pend_store, pend_take, overrun_set;
  logic        handoff, in_win, match, final_beat;

  logic [7:0]  ld_x, ld_y;
  logic [1:0]  ld_h;
  logic [8:0]  ld_d;
  logic [2:0]  side;
  logic [5:0]  side_sq;
  logic [14:0] ld_target;

  logic signed [35:0]          product, prod;
  logic                        prod_valid;
  logic [ACC_WIDTH-1:0]        acc, acc_next;

  // Window test at 9 bits so a center near 0 or 255 never wraps around
  always_comb begin
    in_win = ({1'b0, issue_x} + {7'b0, h} >= {1'b0, cx}) &&
             ({1'b0, issue_x} <= {1'b0, cx} + {7'b0, h}) &&
             ({1'b0, issue_y} + {7'b0, h} >= {1'b0, cy}) &&
             ({1'b0, issue_y} <= {1'b0, cy} + {7'b0, h});
  end

  assign handoff      = (state == RESULT) && result_ready;
  assign issue_block  = pend_full && !handoff;
  assign match        = issue_en && !issue_block && (state == ACCUM) && in_win;
  assign final_beat   = match && ((count + 15'd1) == target);
  assign result_valid = (state == RESULT);
  assign product      = issue_data * weight_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next      = state;
    start           = 1'b0;
    start_from_pend = 1'b0;
    pend_store      = 1'b0;
    pend_take       = 1'b0;
    overrun_set     = 1'b0;
    case (state)
      IDLE: begin
        if (position_select) begin
          start      = 1'b1;
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        if (position_select) start = 1'b1;
        else if (final_beat) state_next = FLUSH;
      end
      FLUSH: begin
        state_next = RESULT;
        if (position_select) begin
          if (pend_full) overrun_set = 1'b1;
          else           pend_store  = 1'b1;
        end
      end
      RESULT: begin
        if (result_ready) begin
          // A held pending position outranks a same-cycle strobe, which is then lost
          if (pend_full) begin
            start           = 1'b1;
            start_from_pend = 1'b1;
            pend_take       = 1'b1;
            state_next      = ACCUM;
            overrun_set     = position_select;
          end else if (position_select) begin
            start      = 1'b1;
            state_next = ACCUM;
          end else begin
            state_next = IDLE;
          end
        end else if (position_select) begin
          if (pend_full) overrun_set = 1'b1;
          else           pend_store  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ld_x      = start_from_pend ? pend_x : position_x;
    ld_y      = start_from_pend ? pend_y : position_y;
    ld_h      = start_from_pend ? pend_h : filter_halfsize;
    ld_d      = start_from_pend ? pend_d : image_depth;
    side      = {ld_h, 1'b1};
    side_sq   = {3'b0, side} * {3'b0, side};
    ld_target = {9'b0, side_sq} * {6'b0, ld_d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cx     <= '0;
      cy     <= '0;
      h      <= '0;
      target <= '0;
      count  <= '0;
    end else if (start) begin
      cx     <= ld_x;
      cy     <= ld_y;
      h      <= ld_h;
      target <= ld_target;
      count  <= '0;
    end else if (match) begin
      count  <= count + 15'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_full <= 1'b0;
      pend_x    <= '0;
      pend_y    <= '0;
      pend_h    <= '0;
      pend_d    <= '0;
    end else if (pend_take) begin
      pend_full <= 1'b0;
    end else if (pend_store) begin
      pend_full <= 1'b1;
      pend_x    <= position_x;
      pend_y    <= position_y;
      pend_h    <= filter_halfsize;
      pend_d    <= image_depth;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              overrun <= 1'b0;
    else if (overrun_set) overrun <= 1'b1;
  end

  always_comb begin
    acc_next = acc;
    if (prod_valid) acc_next = acc + {{(ACC_WIDTH-36){prod[35]}}, prod};
  end

  // A restart drops both the running sum and any product still in stage 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod       <= '0;
      prod_valid <= 1'b0;
      acc        <= '0;
    end else begin
      prod       <= product;
      prod_valid <= match && !start;
      acc        <= start ? '0 : acc_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 result_data <= '0;
    else if (state == FLUSH) result_data <= acc_next;
  end

endmodule

// File: tb/tb_allocator_mac.sv
// Directed and randomized checks of allocator_mac against a window-sum model.
module tb_allocator_mac;
  localparam int AW = 48;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    position_x, position_y;
  logic          position_select;
  logic [1:0]    filter_halfsize;
  logic [8:0]    image_depth;
  logic [7:0]    issue_x, issue_y;
  logic [17:0]   issue_data, weight_data;
  logic          issue_en;
  logic          issue_block;
  logic [AW-1:0] result_data;
  logic          result_valid;
  logic          result_ready;
  logic          overrun;

  allocator_mac #(.ACC_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .position_x(position_x), .position_y(position_y),
    .position_select(position_select),
    .filter_halfsize(filter_halfsize), .image_depth(image_depth),
    .issue_x(issue_x), .issue_y(issue_y),
    .issue_data(issue_data), .weight_data(weight_data),
    .issue_en(issue_en), .issue_block(issue_block),
    .result_data(result_data), .result_valid(result_valid),
    .result_ready(result_ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Reference: one active window, counted beats and an exact integer sum
  bit     m_on;
  int     m_cx, m_cy, m_h, m_cnt, m_target;
  longint m_sum;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_start(input int x, input int y, input int hh, input int d);
    m_on = 1; m_cx = x; m_cy = y; m_h = hh;
    m_target = (2*hh+1) * (2*hh+1) * d;
    m_cnt = 0; m_sum = 0;
  endtask

  function automatic bit model_takes(input int x, input int y);
    int dx, dy;
    dx = (x > m_cx) ? x - m_cx : m_cx - x;
    dy = (y > m_cy) ? y - m_cy : m_cy - y;
    return m_on && (m_cnt < m_target) && (dx <= m_h) && (dy <= m_h);
  endfunction

  task automatic strobe(input int x, input int y, input int hh, input int d);
    position_x = 8'(x); position_y = 8'(y);
    filter_halfsize = 2'(hh); image_depth = 9'(d);
    position_select = 1'b1;
    tick();
    position_select = 1'b0;
  endtask

  task automatic beat(input int x, input int y, input int data, input int weight, input bit en = 1'b1);
    issue_x = 8'(x); issue_y = 8'(y);
    issue_data = 18'(data); weight_data = 18'(weight);
    issue_en = en;
    if (en && model_takes(x, y)) begin
      m_sum += longint'(data) * longint'(weight);
      m_cnt++;
    end
    tick();
    issue_en = 1'b0;
  endtask

  task automatic expect_result(input string tag);
    logic [63:0] e;
    e = 64'(m_sum[AW-1:0]);
    check({tag, "_flush_valid"}, 64'(result_valid), 64'd0);
    tick();
    check({tag, "_valid"}, 64'(result_valid), 64'd1);
    check({tag, "_data"}, 64'(result_data), e);
  endtask

  task automatic consume(input string tag);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check({tag, "_released"}, 64'(result_valid), 64'd0);
  endtask

  initial begin
    int cx, cy, hh, d, off_x, off_y, n;
    rst = 1'b1; position_select = 1'b0; position_x = '0; position_y = '0;
    filter_halfsize = '0; image_depth = '0; issue_x = '0; issue_y = '0;
    issue_data = '0; weight_data = '0; issue_en = 1'b0; result_ready = 1'b0;
    m_on = 0; m_cnt = 0; m_target = 0; m_sum = 0;
    tick(); tick();
    check("rst_valid", 64'(result_valid), 64'd0);
    check("rst_data", 64'(result_data), 64'd0);
    check("rst_block", 64'(issue_block), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    rst = 1'b0;
    tick();

    // Nine in-window beats of 2*3 plus one just outside (x=7)
    strobe(5, 5, 1, 1);
    model_start(5, 5, 1, 1);
    for (int i = 0; i < 9; i++) begin
      if (i == 4) beat(7, 5, 2, 3);
      beat(4 + i % 3, 4 + i / 3, 2, 3);
    end
    expect_result("win3x3");
    check("win3x3_54", 64'(result_data), 64'd54);

    // Hold the result, park (9,9) in pending, then lose (20,20)
    strobe(9, 9, 0, 1);
    check("pend_block", 64'(issue_block), 64'd1);
    check("pend_overrun0", 64'(overrun), 64'd0);
    beat(9, 9, 100, 100);
    check("pend_hold_valid", 64'(result_valid), 64'd1);
    check("pend_hold_data", 64'(result_data), 64'd54);
    strobe(20, 20, 0, 1);
    check("overrun_set", 64'(overrun), 64'd1);
    check("overrun_block", 64'(issue_block), 64'd1);
    result_ready = 1'b1;
    #1;
    check("handoff_unblock", 64'(issue_block), 64'd0);
    tick();
    result_ready = 1'b0;
    check("handoff_valid", 64'(result_valid), 64'd0);
    check("handoff_block", 64'(issue_block), 64'd0);
    model_start(9, 9, 0, 1);
    beat(20, 20, 9, 9);
    beat(9, 9, 5, 7);
    expect_result("pending");
    check("overrun_sticky", 64'(overrun), 64'd1);

    // Handshake and strobe together bypass the pending buffer
    result_ready = 1'b1;
    strobe(3, 3, 0, 1);
    result_ready = 1'b0;
    check("bypass_valid", 64'(result_valid), 64'd0);
    check("bypass_block", 64'(issue_block), 64'd0);
    model_start(3, 3, 0, 1);
    beat(3, 3, -6, 11);
    expect_result("bypass");
    consume("bypass");

    // 5x5x2 window of -1*4, plus one in-window beat during FLUSH
    strobe(2, 2, 2, 2);
    model_start(2, 2, 2, 2);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 25; i++) beat(i % 5, i / 5, -1, 4);
    beat(2, 2, -1, 4);
    check("depth2_valid", 64'(result_valid), 64'd1);
    check("depth2_data", 64'(result_data), 64'(m_sum[AW-1:0]));
    check("depth2_m200", 64'(result_data), 64'(48'hFFFF_FFFF_FF38));
    consume("depth2");

    // Restart after four beats; the fourth is still in stage 1 when the strobe lands
    strobe(10, 10, 1, 1);
    model_start(10, 10, 1, 1);
    for (int i = 0; i < 4; i++) beat(9 + i % 3, 9 + i / 3, 1000, 1000);
    strobe(10, 10, 1, 1);
    model_start(10, 10, 1, 1);
    for (int i = 0; i < 9; i++) beat(9 + i % 3, 9 + i / 3, i + 1, -3);
    expect_result("restart");
    check("restart_m135", 64'(result_data), 64'(48'hFFFF_FFFF_FF79));
    consume("restart");

    // Random windows, centers biased to the coordinate edges, wrapped coordinates included
    for (int t = 0; t < 10; t++) begin
      case ($urandom_range(0, 4))
        0: cx = 0;
        1: cx = 255;
        2: cx = 1;
        default: cx = int'($urandom_range(0, 255));
      endcase
      cy = (t % 2 == 0) ? int'($urandom_range(0, 255)) : 254;
      hh = int'($urandom_range(0, 2));
      d  = int'($urandom_range(1, 3));
      strobe(cx, cy, hh, d);
      model_start(cx, cy, hh, d);
      n = 0;
      while (m_cnt < m_target && n < 3000) begin
        off_x = int'($urandom_range(0, 8)) - 4;
        off_y = int'($urandom_range(0, 8)) - 4;
        beat((cx + off_x) & 255, (cy + off_y) & 255,
             int'($urandom_range(0, 262143)) - 131072,
             int'($urandom_range(0, 262143)) - 131072,
             $urandom_range(0, 4) != 0);
        n++;
      end
      check("rand_bound", 64'(m_cnt == m_target), 64'd1);
      expect_result("rand");
      for (int k = 0; k < 2; k++) begin
        tick();
        check("rand_hold", 64'(result_data), 64'(m_sum[AW-1:0]));
      end
      consume("rand");
    end

    // Reset in the middle of accumulation throws everything away
    strobe(50, 50, 1, 1);
    model_start(50, 50, 1, 1);
    for (int i = 0; i < 5; i++) beat(49 + i % 3, 49 + i / 3, 7, 7);
    #2 rst = 1'b1;
    #1;
    check("midrst_valid", 64'(result_valid), 64'd0);
    check("midrst_data", 64'(result_data), 64'd0);
    check("midrst_block", 64'(issue_block), 64'd0);
    check("midrst_overrun", 64'(overrun), 64'd0);
    tick();
    rst = 1'b0;
    m_on = 0;
    for (int i = 0; i < 12; i++) beat(49 + i % 3, 49 + (i / 3) % 3, 7, 7);
    tick(); tick();
    check("postrst_novalid", 64'(result_valid), 64'd0);

    // First edge after release takes a strobe
    rst = 1'b1;
    tick();
    rst = 1'b0;
    strobe(0, 0, 0, 1);
    model_start(0, 0, 0, 1);
    beat(0, 0, 131071, -131072);
    expect_result("first_edge");
    consume("first_edge");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
